// File: rtl/rfsoc_stream_pkg.sv
// rtl/rfsoc_stream_pkg.sv - shared types and constants for the RFSoC stream reader
package rfsoc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    localparam int READER_BUF_DEPTH = 3;

    function automatic logic [1:0] buf_ptr_next(input logic [1:0] ptr);
        return (ptr == 2'(READER_BUF_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/stream_out_buffer.sv
// rtl/stream_out_buffer.sv - 3-entry circular output buffer hiding the FIFO read latency
module stream_out_buffer
    import rfsoc_stream_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [data_width-1:0] head
);

    logic [data_width-1:0] mem [READER_BUF_DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop  = pop && (occ != 2'd0);
    // a full buffer still accepts a push when the head leaves in the same cycle
    assign do_push = push && ((occ != 2'(READER_BUF_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READER_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= buf_ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= buf_ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains FIFO_memory into a valid/ready stream toward the DAC path
module fifo_stream_reader
    import rfsoc_stream_pkg::*;
#(
    parameter int data_width = 16,
    parameter int len_width  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic                  start,
    input  logic                  abort,
    input  logic [len_width-1:0]  burst_len,
    output logic [data_width-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  underrun,
    output logic [len_width-1:0]  words_sent
);

    reader_state_t        state;
    logic [len_width-1:0] len_q;
    logic [len_width-1:0] requested;
    logic                 inflight;
    logic [1:0]           occ;
    logic                 aborting;
    logic                 continuous;
    logic                 pop;
    logic                 push;
    logic                 starving;

    assign aborting   = abort && (state != IDLE);
    assign continuous = (len_q == '0);
    assign busy       = (state != IDLE);

    // read budget counts words already buffered plus the one still in flight
    assign fifo_read = (state == RUN) && !fifo_empty && !abort &&
                       (({1'b0, occ} + {2'b00, inflight}) < 3'(READER_BUF_DEPTH));

    assign m_tvalid = (occ != 2'd0);
    assign m_tlast  = m_tvalid && !continuous && (words_sent == len_q - len_width'(1));
    assign pop      = m_tvalid && m_tready && !aborting;
    assign push     = inflight && !aborting;

    assign starving = (state == RUN) && (occ == 2'd0) && !inflight && m_tready &&
                      fifo_empty && (continuous || (requested < len_q));

    stream_out_buffer #(
        .data_width(data_width)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (aborting),
        .push     (push),
        .push_data(fifo_dout),
        .pop      (pop),
        .occ      (occ),
        .head     (m_tdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_q      <= '0;
            requested  <= '0;
            words_sent <= '0;
            underrun   <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            inflight <= fifo_read;
            if (fifo_read) begin
                requested <= requested + len_width'(1);
            end
            if (pop) begin
                words_sent <= words_sent + len_width'(1);
            end
            if (starving) begin
                underrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        len_q      <= burst_len;
                        requested  <= '0;
                        words_sent <= '0;
                        underrun   <= 1'b0;
                    end
                end
                RUN: begin
                    if (aborting) begin
                        state <= IDLE;
                    end else if (fifo_read && !continuous &&
                                 (requested + len_width'(1) == len_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (aborting || (pop && m_tlast)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty;
    logic          fifo_read;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          busy;
    logic          underrun;
    logic [LW-1:0] words_sent;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.data_width(DW), .len_width(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .start     (start),
        .abort     (abort),
        .burst_len (burst_len),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy),
        .underrun  (underrun),
        .words_sent(words_sent)
    );

    // FIFO with one-cycle read latency
    logic [DW-1:0] fmem [0:1023];
    int            wr_idx = 0;
    int            rd_idx = 0;
    logic          fifo_clear = 1'b0;

    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge clk) begin
        if (fifo_clear) begin
            rd_idx <= wr_idx;
        end else if (fifo_read) begin
            fifo_dout <= fmem[rd_idx];
            rd_idx    <= rd_idx + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
    endtask

    task automatic clear_fifo();
        fifo_clear = 1'b1;
        tick();
        fifo_clear = 1'b0;
    endtask

    // Reference model: words leave the stream in FIFO read order, one count per beat
    logic [DW-1:0] exp_q[$];
    int            beats = 0;
    logic [LW-1:0] mlen = '0;
    logic          m_busy = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          ur_chk = 1'b0;
    logic          exp_last;
    logic          acc_start;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                beats      = 0;
                mlen       = '0;
                m_busy     = 1'b0;
                prev_stall = 1'b0;
                ur_chk     = 1'b0;
            end else begin
                exp_last = m_tvalid && (mlen != '0) && (LW'(beats) == mlen - LW'(1));
                if (m_tvalid) begin
                    check("pending_word_exists", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("m_tdata", m_tdata, exp_q[0]);
                end
                check("m_tlast", m_tlast, exp_last);
                check("words_sent", words_sent, LW'(beats));
                check("busy", busy, m_busy);
                check("read_ahead_le3", (exp_q.size() <= 3), 1);
                if (fifo_read) check("read_while_empty", fifo_empty, 0);
                if (abort && m_busy) check("read_in_abort", fifo_read, 0);
                if (prev_stall) begin
                    check("stall_tvalid", m_tvalid, 1);
                    check("stall_tdata", m_tdata, prev_data);
                end
                if (ur_chk) check("underrun_cleared", underrun, 0);

                ur_chk     = 1'b0;
                prev_stall = m_tvalid && !m_tready && !(abort && m_busy);
                prev_data  = m_tdata;
                acc_start  = start && !m_busy;
                if (abort && m_busy) begin
                    exp_q.delete();
                    m_busy = 1'b0;
                end else begin
                    if (m_tvalid && m_tready && exp_q.size() != 0) begin
                        exp_q.delete(0);
                        beats++;
                        if (exp_last) m_busy = 1'b0;
                    end
                    if (fifo_read) exp_q.push_back(fmem[rd_idx]);
                end
                if (acc_start) begin
                    m_busy = 1'b1;
                    mlen   = burst_len;
                    beats  = 0;
                    ur_chk = 1'b1;
                end
            end
        end
    end

    int            tl_count;
    logic [DW-1:0] tl_data;

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        tl_count = 0;
        forever begin
            @(negedge clk);
            if (m_tvalid && m_tready && m_tlast) begin
                tl_count++;
                tl_data = m_tdata;
            end
            if (!busy || n >= budget) break;
            tick();
            n++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fifo_read"}, fifo_read, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_words_sent"}, words_sent, 0);
    endtask

    task automatic run_basic(input string tag);
        tick();
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        m_tready  = 1'b1;
        burst_len = 16'd4;
        start     = 1'b1;
        @(negedge clk);
        check({tag, "_c0_busy"}, busy, 0);
        tick();
        start     = 1'b0;
        burst_len = 16'd9;
        @(negedge clk);
        check({tag, "_c1_busy"}, busy, 1);
        check({tag, "_c1_fifo_read"}, fifo_read, 1);
        check({tag, "_c1_tvalid"}, m_tvalid, 0);
        tick();
        @(negedge clk);
        check({tag, "_c2_tvalid"}, m_tvalid, 0);
        for (int c = 3; c <= 6; c++) begin
            tick();
            @(negedge clk);
            check({tag, "_beat_tvalid"}, m_tvalid, 1);
            check({tag, "_beat_tdata"}, m_tdata, 32'(c - 2));
            check({tag, "_beat_tlast"}, m_tlast, (c == 6));
        end
        tick();
        @(negedge clk);
        check({tag, "_c7_busy"}, busy, 0);
        check({tag, "_c7_words_sent"}, words_sent, 4);
        check({tag, "_c7_tvalid"}, m_tvalid, 0);
    endtask

    initial begin
        int reads;
        int beats3;
        int tl3;
        int n;
        int nxt;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b1;

        run_basic("s1");

        // backpressure: three words read ahead, then drain in order
        tick();
        clear_fifo();
        for (int i = 0; i < 10; i++) push_word(DW'(16'h00a0 + i));
        burst_len = 16'd10;
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            start    = (c == 0);
            m_tready = !(c >= 2 && c <= 9);
            @(negedge clk);
            if (fifo_read) reads++;
            tick();
        end
        start    = 1'b0;
        m_tready = 1'b1;
        check("s2_reads_before_pop", reads, 3);
        wait_idle("s2", 60);
        check("s2_words_sent", words_sent, 10);
        check("s2_fifo_drained", fifo_empty, 1);
        check("s2_tlast_data", tl_data, 16'h00a9);

        // continuous mode, abort after 20 beats
        tick();
        clear_fifo();
        for (int i = 0; i < 4; i++) push_word(DW'(16'h0100 + i));
        nxt = 4;
        burst_len = 16'd0;
        start = 1'b1;
        m_tready = 1'b1;
        beats3 = 0;
        tl3 = 0;
        n = 0;
        while (beats3 < 20 && n < 200) begin
            @(negedge clk);
            if (m_tvalid && m_tready) beats3++;
            if (m_tlast) tl3++;
            tick();
            start = 1'b0;
            push_word(DW'(16'h0100 + nxt));
            nxt++;
            n++;
        end
        check("s3_beats", beats3, 20);
        abort = 1'b1;
        @(negedge clk);
        check("s3_abort_fifo_read", fifo_read, 0);
        check("s3_abort_busy", busy, 1);
        if (m_tlast) tl3++;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("s3_after_tvalid", m_tvalid, 0);
        check("s3_after_busy", busy, 0);
        check("s3_words_sent", words_sent, 20);
        check("s3_tlast_count", tl3, 0);

        // starvation sets sticky underrun
        tick();
        clear_fifo();
        for (int i = 0; i < 3; i++) push_word(DW'(16'h0200 + i));
        burst_len = 16'd8;
        start = 1'b1;
        m_tready = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("s4_underrun_set", underrun, 1);
        check("s4_words_sent_3", words_sent, 3);
        check("s4_busy", busy, 1);
        check("s4_tvalid", m_tvalid, 0);
        tick();
        for (int i = 3; i < 8; i++) push_word(DW'(16'h0200 + i));
        wait_idle("s4", 60);
        check("s4_underrun_held", underrun, 1);
        check("s4_words_sent_8", words_sent, 8);
        check("s4_tlast_data", tl_data, 16'h0207);
        tick();
        push_word(16'h0250);
        burst_len = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("s4_restart_underrun", underrun, 0);
        wait_idle("s4b", 20);

        // asynchronous reset mid-burst
        tick();
        clear_fifo();
        for (int i = 0; i < 3; i++) push_word(DW'(16'h0300 + i));
        burst_len = 16'd4;
        for (int c = 0; c < 7; c++) begin
            start    = (c == 0);
            m_tready = (c == 3);
            @(negedge clk);
            tick();
        end
        start = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        check("s5_pre_tvalid", m_tvalid, 1);
        check("s5_pre_words_sent", words_sent, 1);
        check("s5_pre_tdata", m_tdata, 16'h0301);
        tick();
        reset = 1'b0;
        #1;
        check_reset_values("s5_rst");
        tick();
        reset = 1'b1;
        clear_fifo();
        run_basic("s5_after");

        // start during RUN is ignored
        tick();
        clear_fifo();
        for (int i = 1; i <= 4; i++) push_word(DW'(16'h0400 + i));
        burst_len = 16'd4;
        m_tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            start = (c == 0) || (c == 2);
            if (c == 2) burst_len = 16'd2;
            @(negedge clk);
            tick();
        end
        start = 1'b0;
        wait_idle("s6", 30);
        check("s6_words_sent", words_sent, 4);
        check("s6_tlast_count", tl_count, 1);
        check("s6_tlast_data", tl_data, 16'h0404);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
